// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//   Receives a byte-stream boot frame and writes it into instruction memory.
//   The processor is held while loading.
//   Frame: HDR_BYTE, word count N (16 bit, MSB first), N words of 4 bytes
//   (MSB first), then a checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
//
//   Optional feature macro: INSTR_LOADER_CHECKSUM_EN (enables the CSUM state
//   and the running XOR over the data bytes).
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   start      : pulse; re-arms the loader from DONE or ERROR
//   in_valid   : byte-stream valid
//   in_data    : byte-stream data
//   in_ready   : byte accepted on any cycle where in_valid && in_ready
//   mem_we     : one-cycle write strobe per assembled word
//   mem_addr   : word address of the current write
//   mem_wdata  : instruction word being written
//   cpu_hold   : processor frozen while high (every state except DONE)
//   load_done  : level, frame loaded successfully
//   load_error : level, frame rejected
//   dbg_state  : current FSM state encoding
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready are
// both high; in_ready depends only on the FSM state, never on in_valid.
// ---------------------------------------------------------------------------
module instr_loader #(
   parameter int         ADDR_W   = 10,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CNT_HI = 3'd1,
      CNT_LO = 3'd2,
      DATA   = 3'd3,
`ifdef INSTR_LOADER_CHECKSUM_EN
      CSUM   = 3'd4,
`endif
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

   // State entered once the last data byte (or a zero count) is seen.
`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CSUM;
`else
   localparam state_t END_STATE = DONE;
`endif

   // Largest legal word count; the index register is 17 bits wide so it can
   // reach this value after the last write without wrapping.
   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   state_t      state, state_nx;
   logic [15:0] count;
   logic [16:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] asm_word;   // first three bytes of the word in flight
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   logic        accept;
   logic [15:0] cnt_full;
   logic        last_word;

   assign accept    = in_valid && in_ready;
   assign cnt_full  = {count[15:8], in_data};
   assign last_word = (byte_cnt == 2'd3) && ((word_idx + 17'd1) == {1'b0, count});

   // Next-state and state-decoded outputs
   always_comb begin
      state_nx   = state;
      in_ready   = 1'b0;
      cpu_hold   = 1'b1;
      load_done  = 1'b0;
      load_error = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept && in_data == HDR_BYTE) state_nx = CNT_HI;
         end
         CNT_HI: begin
            in_ready = 1'b1;
            if (accept) state_nx = CNT_LO;
         end
         CNT_LO: begin
            in_ready = 1'b1;
            if (accept) begin
               if ({1'b0, cnt_full} > MAX_WORDS) state_nx = ERROR;
               else if (cnt_full == 16'd0)       state_nx = END_STATE;
               else                              state_nx = DATA;
            end
         end
         DATA: begin
            in_ready = 1'b1;
            if (accept && last_word) state_nx = END_STATE;
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         CSUM: begin
            in_ready = 1'b1;
            if (accept) state_nx = (in_data == csum) ? DONE : ERROR;
         end
`endif
         DONE: begin
            cpu_hold  = 1'b0;
            load_done = 1'b1;
            if (start) state_nx = IDLE;
         end
         ERROR: begin
            load_error = 1'b1;
            if (start) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign dbg_state = state;

   // State register and datapath
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         word_idx  <= '0;
         byte_cnt  <= '0;
         asm_word  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         state  <= state_nx;
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               // Fresh frame: clear everything left from an abandoned one.
               if (accept && in_data == HDR_BYTE) begin
                  count    <= '0;
                  word_idx <= '0;
                  byte_cnt <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            CNT_HI: if (accept) count[15:8] <= in_data;
            CNT_LO: if (accept) count[7:0]  <= in_data;
            DATA: begin
               if (accept) begin
                  asm_word <= {asm_word[15:0], in_data};
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum     <= csum ^ in_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= {asm_word, in_data};
                     mem_addr  <= word_idx[ADDR_W-1:0];
                     word_idx  <= word_idx + 17'd1;
                  end
               end
            end
            DONE, ERROR: begin
               if (start) begin
                  count    <= '0;
                  word_idx <= '0;
                  byte_cnt <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  localparam int AW = 10;
  localparam logic [7:0] HDR = 8'hA5;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [2:0]    dbg_state;

  instr_loader #(.ADDR_W(AW), .HDR_BYTE(HDR)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [AW+31:0] exp_q[$];
  logic [31:0]    wq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe pops one expected {addr, data}
  always @(negedge clock) begin
    if (!reset && mem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("unexpected_write", {32'd0, mem_wdata}, 64'd0);
      else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[AW+31:32]));
        check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
  end

  // drivers
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b1;   // start must lose to reset
    repeat (2) @(negedge clock);
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_error", 64'(load_error), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("start_cpu_hold", 64'(cpu_hold), 64'd1);
    check("start_done_clr", 64'(load_done), 64'd0);
    check("start_err_clr", 64'(load_error), 64'd0);
    check("start_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, 1)) @(negedge clock);
    @(negedge clock);
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 20) begin @(negedge clock); n++; end
    if (!in_ready) check("stall_timeout", 64'd1, 64'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Sends HDR, count = wq.size(), the words in wq and (if enabled) checksum.
  task automatic send_frame(input bit bad_csum);
    logic [15:0] n;
    logic [7:0]  cs;
    n  = 16'(wq.size());
    cs = 8'h00;
    send_byte(HDR);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < wq.size(); i++) begin
      exp_q.push_back({AW'(i), wq[i]});
      for (int k = 3; k >= 0; k--) begin
        logic [7:0] b;
        b = wq[i][k*8 +: 8];
        cs = cs ^ b;
        send_byte(b);
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'h04) : cs);
`else
    if (bad_csum) cs = 8'h00;
`endif
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(load_done || load_error) && n < 60) begin @(negedge clock); n++; end
    if (!(load_done || load_error)) check({tag, "_timeout"}, 64'd1, 64'd0);
    repeat (2) @(negedge clock);
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 64'(load_done), 64'd1);
    check({tag, "_err"}, 64'(load_error), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    do_reset();
    check_reset_state();

    // Reference frame: two words
    wq = '{32'h2008_0005, 32'hAC0A_0000};
    send_frame(1'b0);
    wait_end("ref");
    expect_done("ref");
    check("ref_writes", 64'(wr_cnt), 64'd2);

    // Junk bytes before a one-word frame are discarded
    pulse_start();
    send_byte(8'h11);
    send_byte(8'hFF);
    @(negedge clock);
    check("junk_no_err", 64'(load_error), 64'd0);
    check("junk_ready", 64'(in_ready), 64'd1);
    w0 = wr_cnt;
    wq = '{$urandom()};
    send_frame(1'b0);
    wait_end("junk");
    expect_done("junk");
    check("junk_writes", 64'(wr_cnt - w0), 64'd1);

    // Zero-count reload from DONE
    pulse_start();
    w0 = wr_cnt;
    wq.delete();
    send_frame(1'b0);
    wait_end("zero");
    expect_done("zero");
    check("zero_writes", 64'(wr_cnt - w0), 64'd0);

    // Random multi-word frame
    pulse_start();
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back($urandom());
    send_frame(1'b0);
    wait_end("multi");
    expect_done("multi");

    // Oversized count 0x0401 > 1024 -> ERROR after the count, no writes
    pulse_start();
    w0 = wr_cnt;
    send_byte(HDR); send_byte(8'h04); send_byte(8'h01);
    repeat (2) @(negedge clock);
    check("big_err", 64'(load_error), 64'd1);
    check("big_hold", 64'(cpu_hold), 64'd1);
    check("big_ready", 64'(in_ready), 64'd0);
    check("big_done", 64'(load_done), 64'd0);
    check("big_writes", 64'(wr_cnt - w0), 64'd0);
    // start in a loading state is ignored; this one re-arms from ERROR
    pulse_start();

    // Exactly 1024 is legal; abandon it mid-word with reset
    send_byte(HDR); send_byte(8'h04); send_byte(8'h00);
    @(negedge clock);
    check("max_no_err", 64'(load_error), 64'd0);
    check("max_ready", 64'(in_ready), 64'd1);
    send_byte(8'hDE); send_byte(8'hAD);
    @(negedge clock); start = 1'b1;       // ignored while loading
    @(negedge clock); start = 1'b0;
    check("start_ignored_err", 64'(load_error), 64'd0);
    check("start_ignored_hold", 64'(cpu_hold), 64'd1);
    do_reset();
    check_reset_state();
    w0 = wr_cnt;
    wq = '{32'h1234_5678};
    send_frame(1'b0);
    wait_end("after_rst");
    expect_done("after_rst");
    check("after_rst_writes", 64'(wr_cnt - w0), 64'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Bad checksum: word stays written, frame rejected
    pulse_start();
    w0 = wr_cnt;
    wq = '{32'h0102_0304};
    send_frame(1'b1);
    wait_end("csum");
    check("csum_err", 64'(load_error), 64'd1);
    check("csum_hold", 64'(cpu_hold), 64'd1);
    check("csum_ready", 64'(in_ready), 64'd0);
    check("csum_writes", 64'(wr_cnt - w0), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
